counter_seq_checker: RTL and testbench

Receive-side monitor for the modulo-2^WIDTH free-running counters our blocks produce. It samples a counter value on a valid strobe, predicts the next value, and runs an acquire/lock/lose state machine. It counts sequence errors in a saturating counter. It sits downstream of any counter source, either on a bus tap or in a test harness, and reports lock status and error statistics.

---
 rtl/counter_seq_checker.sv | 145 ++++++++++++++
 tb/tb_counter_seq_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/counter_seq_checker.sv
// Sequence monitor for modulo-2^WIDTH counters: acquire/lock/lose tracking plus saturating error count.
// Optional: define COUNTER_SEQ_CHECKER_RESET_DETECT_EN to treat an unexpected 0 while locked as a writer resync.
module counter_seq_checker #(
    parameter int WIDTH      = 2,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic             clear_i,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic             resync_pulse,
    output logic [ERR_W-1:0] err_count
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOSING  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [GW-1:0]    good_run_reg, good_run_next;
    logic [BW-1:0]    bad_run_reg, bad_run_next;
    // Holds prev+1 directly, so the match compare needs no adder on the sample path.
    logic [WIDTH-1:0] expected_reg, expected_next;
    logic             locked_reg, locked_next;
    logic             err_pulse_reg, resync_pulse_reg;
    logic [ERR_W-1:0] err_count_reg, err_count_next;

    logic match;
    logic zero_resync;
    logic err_hit;
    logic resync_hit;

    assign match = (count_i == expected_reg);

`ifdef COUNTER_SEQ_CHECKER_RESET_DETECT_EN
    assign zero_resync = (count_i == '0);
`else
    assign zero_resync = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            good_run_reg     <= '0;
            bad_run_reg      <= '0;
            expected_reg     <= WIDTH'(1);
            locked_reg       <= 1'b0;
            err_pulse_reg    <= 1'b0;
            resync_pulse_reg <= 1'b0;
            err_count_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            good_run_reg     <= good_run_next;
            bad_run_reg      <= bad_run_next;
            expected_reg     <= expected_next;
            locked_reg       <= locked_next;
            err_pulse_reg    <= err_hit;
            resync_pulse_reg <= resync_hit;
            err_count_reg    <= err_count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        good_run_next = good_run_reg;
        bad_run_next  = bad_run_reg;
        err_hit       = 1'b0;
        resync_hit    = 1'b0;
        if (valid_i) begin
            case (state_reg)
                IDLE: begin
                    state_next    = ACQUIRE;
                    good_run_next = '0;
                end
                ACQUIRE: begin
                    if (!match) begin
                        good_run_next = '0;
                    end else if (good_run_reg == LOCK_LAST) begin
                        state_next   = LOCKED;
                        bad_run_next = '0;
                    end else begin
                        good_run_next = good_run_reg + 1'b1;
                    end
                end
                LOCKED, LOSING: begin
                    if (match) begin
                        state_next   = LOCKED;
                        bad_run_next = '0;
                    end else if (zero_resync) begin
                        resync_hit   = 1'b1;
                        state_next   = LOCKED;
                        bad_run_next = '0;
                    end else begin
                        // bad_run is always 0 in LOCKED, so one compare covers both states.
                        err_hit = 1'b1;
                        if (bad_run_reg == LOSS_LAST) begin
                            state_next    = ACQUIRE;
                            good_run_next = '0;
                        end else begin
                            state_next   = LOSING;
                            bad_run_next = bad_run_reg + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        locked_next   = (state_next == LOCKED) || (state_next == LOSING);
        expected_next = valid_i ? count_i + WIDTH'(1) : expected_reg;
        if (err_hit) begin
            if (clear_i)
                err_count_next = ERR_W'(1);
            else if (&err_count_reg)
                err_count_next = err_count_reg;
            else
                err_count_next = err_count_reg + 1'b1;
        end else if (clear_i) begin
            err_count_next = '0;
        end else begin
            err_count_next = err_count_reg;
        end
    end

    assign locked       = locked_reg;
    assign expected     = expected_reg;
    assign err_pulse    = err_pulse_reg;
    assign resync_pulse = resync_pulse_reg;
    assign err_count    = err_count_reg;
endmodule

// File: tb/tb_counter_seq_checker.sv
// Randomized and directed bench for counter_seq_checker against a rule-level reference model.
module tb_counter_seq_checker;
    localparam int WIDTH      = 2;
    localparam int LOCK_COUNT = 4;
    localparam int LOSS_COUNT = 2;
    localparam int ERR_W      = 2;
    localparam int MOD        = 1 << WIDTH;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;
`ifdef COUNTER_SEQ_CHECKER_RESET_DETECT_EN
    localparam bit RESET_DETECT = 1'b1;
`else
    localparam bit RESET_DETECT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic [WIDTH-1:0] count_i = '0;
    logic             clear_i = 1'b0;
    logic             locked;
    logic [WIDTH-1:0] expected;
    logic             err_pulse;
    logic             resync_pulse;
    logic [ERR_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    // Reference model: plain counters derived from the sequence rules.
    bit m_seen, m_locked, m_err_p, m_rs_p;
    int m_good, m_bad, m_prev, m_err;

    counter_seq_checker #(
        .WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .count_i(count_i), .clear_i(clear_i),
        .locked(locked), .expected(expected), .err_pulse(err_pulse),
        .resync_pulse(resync_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_locked = 0; m_err_p = 0; m_rs_p = 0;
        m_good = 0; m_bad = 0; m_prev = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit clr);
        bit is_match;
        m_err_p = 0;
        m_rs_p  = 0;
        if (v) begin
            is_match = (c == (m_prev + 1) % MOD);
            if (!m_seen) begin
                m_seen = 1;
                m_good = 0;
            end else if (!m_locked) begin
                m_good = is_match ? m_good + 1 : 0;
                if (m_good >= LOCK_COUNT) begin
                    m_locked = 1;
                    m_bad    = 0;
                end
            end else if (is_match) begin
                m_bad = 0;
            end else if (RESET_DETECT && c == 0) begin
                m_rs_p = 1;
                m_bad  = 0;
            end else begin
                m_err_p = 1;
                m_bad++;
                if (m_bad >= LOSS_COUNT) begin
                    m_locked = 0;
                    m_good   = 0;
                end
            end
            m_prev = c;
        end
        if (m_err_p)
            m_err = clr ? 1 : ((m_err < ERR_MAX) ? m_err + 1 : ERR_MAX);
        else if (clr)
            m_err = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".locked"}, int'(locked), int'(m_locked));
        check_eq({tag, ".expected"}, int'(expected), (m_prev + 1) % MOD);
        check_eq({tag, ".err_pulse"}, int'(err_pulse), int'(m_err_p));
        check_eq({tag, ".resync_pulse"}, int'(resync_pulse), int'(m_rs_p));
        check_eq({tag, ".err_count"}, int'(err_count), m_err);
    endtask

    task automatic step(input string tag, input bit v, input int c, input bit clr);
        valid_i = v;
        count_i = c[WIDTH-1:0];
        clear_i = clr;
        @(posedge clk);
        model_step(v, c, clr);
        #1;
        $display("%s v=%0d c=%0d clr=%0d -> locked=%0d exp=%0d ep=%0d rp=%0d ec=%0d",
                 tag, v, c, clr, locked, expected, err_pulse, resync_pulse, err_count);
        check_outputs(tag);
    endtask

    // Asserts rst between edges and checks outputs react before any clock.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check_eq({tag, ".locked"}, int'(locked), 0);
        check_eq({tag, ".expected"}, int'(expected), 1);
        check_eq({tag, ".err_pulse"}, int'(err_pulse), 0);
        check_eq({tag, ".resync_pulse"}, int'(resync_pulse), 0);
        check_eq({tag, ".err_count"}, int'(err_count), 0);
        model_reset();
        valid_i = 1'b0;
        clear_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        $display("%s reset released", tag);
    endtask

    task automatic send(input string tag, input int vals[$]);
        foreach (vals[i]) step(tag, 1'b1, vals[i], 1'b0);
    endtask

    initial begin
        int c;
        bit v, clr;
        model_reset();
        do_reset("reset0");

        send("acquire", '{0, 1, 2, 3, 0});
        check_eq("acquire.locked_final", int'(locked), 1);
        send("glitch", '{1, 3, 0});
        send("loss", '{1, 3, 1});
        check_eq("loss.unlocked", int'(locked), 0);
        send("relock", '{2, 3, 0, 1});
        check_eq("relock.locked_final", int'(locked), 1);

        for (int k = 0; k < 5; k++) send("sat", '{3, 0});
        check_eq("sat.err_count", int'(err_count), ERR_MAX);
        step("sat_clear", 1'b1, 2, 1'b1);
        check_eq("sat_clear.err_count", int'(err_count), 1);

        send("gapfill", '{3, 0, 1, 2, 3, 0});
        for (int k = 0; k < 10; k++) step("gap", 1'b0, $urandom_range(MOD - 1), 1'b0);

        send("macro", '{1, 2, 0});
        send("midstream", '{1, 2});
        do_reset("reset_mid");

        for (int k = 0; k < 600; k++) begin
            v   = ($urandom_range(9) < 8);
            clr = ($urandom_range(19) == 0);
            c   = ($urandom_range(9) < 7) ? (m_prev + 1) % MOD : $urandom_range(MOD - 1);
            step("rand", v, c, clr);
            if (k == 300) do_reset("reset_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
